// File: rtl/fifo_serial_reader.sv
// fifo_serial_reader: drains a synchronous-read FIFO and sends each word out
// as an asynchronous frame (start 0, DATA_WIDTH bits LSB-first, stop 1).
// Keeps a wrapping count of completed frames.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | line high, waiting for enable=1 and a non-empty FIFO
//   POP   | read strobe high for this single cycle
//   LOAD  | FIFO data valid; captured into the shift register at edge
//   START | start bit (0) for CLKS_PER_BIT cycles
//   DATA  | DATA_WIDTH data bits, LSB first, CLKS_PER_BIT cycles each
//   STOP  | stop bit (1); frame counted on its last cycle
module fifo_serial_reader #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] dataOut,
  output logic                  read,
  output logic                  txd,
  output logic                  busy,
  output logic [7:0]            byteCount
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         bit_cnt;
  logic [IW-1:0]         bit_idx;
  logic                  bit_end;
  logic                  can_pop;

  // Inputs only steer the next-state decision; outputs stay purely registered.
  assign bit_end = (bit_cnt == BIT_LAST);
  assign can_pop = enable & ~empty;

  // Frame sequencer with registered read/txd/busy and the frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      txd       <= 1'b1;
      read      <= 1'b0;
      busy      <= 1'b0;
      byteCount <= 8'd0;
    end else begin
      read <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (can_pop) begin
            state <= POP;
            read  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shift   <= dataOut;
          txd     <= 1'b0;
          bit_cnt <= '0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              // present the next bit while dropping the one just sent
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt   <= '0;
            byteCount <= byteCount + 8'd1;
            // chain straight into the next pop to keep the gap at two cycles
            if (can_pop) begin
              state <= POP;
              read  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Bench for fifo_serial_reader: a FIFO model feeds the DUT, the stimulus
// pushes each expected byte into a scoreboard queue, and a line monitor
// decodes every frame on txd and checks it against the queue.
module tb_fifo_serial_reader;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       empty;
  logic [7:0] dataOut = 8'h00;
  logic       read;
  logic       txd;
  logic       busy;
  logic [7:0] byteCount;

  int vectors = 0;
  int miscompares = 0;

  // FIFO model
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign empty = (wr_ptr == rd_ptr);

  // scoreboard / monitor state
  logic [7:0] exp_q[$];
  int         read_times[$];
  int         read_pulses = 0;
  int         last_read_cyc = -100;
  logic       prev_read = 1'b0;
  int         cyc = 0;

  fifo_serial_reader #(.CLKS_PER_BIT(C), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .empty(empty),
    .dataOut(dataOut), .read(read), .txd(txd), .busy(busy),
    .byteCount(byteCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read FIFO: data valid the cycle after read
  always @(posedge clk) begin
    if (read && (rd_ptr != wr_ptr)) begin
      dataOut <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(b);
  endtask

  task automatic wait_done(input int target, input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && byteCount == 8'(target)) && n < maxc);
    check("done_bytecount", {24'd0, byteCount}, target);
    check("done_busy", {31'd0, busy}, 0);
  endtask

  task automatic wait_read(input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (read !== 1'b1 && n < maxc);
    check("read_seen", {31'd0, read}, 1);
  endtask

  // line monitor: decode frames on txd and compare against the scoreboard
  initial begin
    logic       in_frame;
    int         f;
    int         bad;
    int         first_bad;
    logic [9:0] fr;
    logic [7:0] b;
    in_frame = 1'b0;
    f = 0;
    bad = 0;
    first_bad = -1;
    fr = '1;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (read) begin
        read_pulses++;
        read_times.push_back(cyc);
        check("read_width", {31'd0, prev_read}, 0);
        check("read_while_empty", {31'd0, empty}, 0);
        last_read_cyc = cyc;
      end
      prev_read = read;
      if (!rst_n) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && txd == 1'b0) begin
          in_frame = 1'b1;
          f = 0;
          bad = 0;
          first_bad = -1;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            fr = 10'h000;
            b = 8'h00;
          end else begin
            b = exp_q.pop_front();
            fr = {1'b1, b, 1'b0};
          end
          check("start_latency", cyc - last_read_cyc, 2);
        end
        if (in_frame) begin
          if (txd !== fr[f / C]) begin
            bad++;
            if (first_bad < 0) first_bad = f;
          end
          f++;
          if (f == 10 * C) begin
            in_frame = 1'b0;
            vectors++;
            if (bad != 0) begin
              miscompares++;
              $display("FAIL frame %02h: %0d wrong line cycles, first at cycle %0d, required 0",
                       b, bad, first_bad);
            end
          end
        end
      end
    end
  end

  initial begin
    int p0;
    int viol;

    // reset held with data available and enable high
    rst_n  = 1'b0;
    enable = 1'b1;
    push_byte(8'hA5);
    repeat (3) begin
      @(negedge clk);
      check("rst_txd", {31'd0, txd}, 1);
      check("rst_read", {31'd0, read}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_bytecount", {24'd0, byteCount}, 0);
    end
    rst_n = 1'b1;

    // single byte 0xA5
    wait_done(1, 100);
    check("a5_read_pulses", read_pulses, 1);

    // back-to-back 0x01, 0x03, 0x02 from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("b2b_bytecount_clr", {24'd0, byteCount}, 0);
    read_times.delete();
    push_byte(8'h01);
    push_byte(8'h03);
    push_byte(8'h02);
    wait_done(3, 200);
    check("b2b_reads", read_times.size(), 3);
    if (read_times.size() == 3) begin
      check("b2b_gap1", read_times[1] - read_times[0], 42);
      check("b2b_gap2", read_times[2] - read_times[1], 42);
    end
    check("b2b_empty", {31'd0, empty}, 1);

    // enable low with data waiting
    enable = 1'b0;
    push_byte(8'h5A);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (read !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("disabled_quiet", viol, 0);
    enable = 1'b1;
    @(negedge clk);
    check("enable_read", {31'd0, read}, 1);
    wait_done(4, 100);

    // enable dropped during DATA of 0x3C
    p0 = read_pulses;
    push_byte(8'h3C);
    push_byte(8'h77);
    wait_read(10);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_done(5, 100);
    check("drop_one_read", read_pulses - p0, 1);
    repeat (10) @(negedge clk);
    check("drop_no_more_read", read_pulses - p0, 1);
    check("drop_fifo_kept", {31'd0, empty}, 0);

    // reset mid-DATA: frame of 0x77 aborted, then a clean frame of 0xC3
    enable = 1'b1;
    wait_read(10);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_txd", {31'd0, txd}, 1);
    check("abort_bytecount", {24'd0, byteCount}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
    push_byte(8'hC3);
    rst_n = 1'b1;
    wait_done(1, 100);
    check("final_scoreboard_empty", exp_q.size(), 0);
    check("final_fifo_empty", {31'd0, empty}, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
